// File: rtl/ram.sv
// Single-port synchronous RAM with a shared bidirectional data bus.
// Reads are registered (one edge of latency) and driven onto the bus while
// isReading is high; writes take the bus value while isReading is low.
// Optional feature macro: RAM_CLEAR_EN -- when defined, the array is swept
// to zero after every reset release and ready stays low until the sweep
// completes. Without it, reset leaves the array contents untouched.
module ram #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 2048
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic                  isReading,
  inout  wire  [0:DATA_WIDTH-1] data,
  output logic                  ready
);

  logic [0:DATA_WIDTH-1] ram_memory [DEPTH];
  logic [0:DATA_WIDTH-1] rd_q;
  logic                  ready_q;

  // Write-port mux: either the external master or the clear sweep
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [0:DATA_WIDTH-1] mem_wdata;

  // External accesses are only honoured outside reset and once ready
  logic ext_wr;
  logic ext_rd;

  assign ext_wr = !reset && ready_q && !isReading;
  assign ext_rd = !reset && ready_q &&  isReading;

  // The ram only drives the bus while a read is selected
  assign data  = isReading ? rd_q : 'z;
  assign ready = ready_q;

`ifdef RAM_CLEAR_EN

  typedef enum logic {
    ST_SWEEP,
    ST_READY
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(DEPTH - 1);

  state_t                state_q;
  state_t                state_d;
  logic [ADDR_WIDTH-1:0] sweep_q;
  logic                  sweep_we;
  logic                  ready_d;

  // State register and sweep counter; reset parks the sweep at word 0 so
  // a reset arriving mid-sweep restarts it from the beginning
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_SWEEP;
      sweep_q <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      if (sweep_we) begin
        sweep_q <= sweep_q + ADDR_WIDTH'(1);
      end
    end
  end

  // Next-state: leave the sweep after the last word has been written
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SWEEP: if (sweep_q == LAST_WORD) state_d = ST_READY;
      ST_READY: state_d = ST_READY;
      default:  state_d = ST_SWEEP;
    endcase
  end

  // Outputs: ready is registered from the state, so it rises one edge
  // after the final word is cleared
  always_comb begin
    sweep_we = 1'b0;
    ready_d  = 1'b0;
    case (state_q)
      ST_SWEEP: sweep_we = 1'b1;
      ST_READY: ready_d  = 1'b1;
      default:  sweep_we = 1'b0;
    endcase
  end

  // Write-port select: the sweep owns the port until ready
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = address;
    mem_wdata = data;
    if (reset) begin
      mem_we = 1'b0;
    end else if (sweep_we) begin
      mem_we    = 1'b1;
      mem_addr  = sweep_q;
      mem_wdata = '0;
    end else if (ext_wr) begin
      mem_we = 1'b1;
    end
  end

`else

  // Ready simply follows reset: low on a reset edge, high on any other
  always_ff @(posedge clk) begin
    ready_q <= !reset;
  end

  // Write-port select: only the external master writes
  always_comb begin
    mem_we    = ext_wr;
    mem_addr  = address;
    mem_wdata = data;
  end

`endif

  // Storage array write; contents are never reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      ram_memory[mem_addr] <= mem_wdata;
    end
  end

  // Read register: cleared on reset, otherwise holds between reads so the
  // last word reappears as soon as isReading returns high
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q <= '0;
    end else if (ext_rd) begin
      rd_q <= ram_memory[address];
    end
  end

endmodule

// File: tb/tb_ram.sv
// Self-checking bench for ram: table of directed read/write vectors plus
// hand-written sequences for bus direction, read-register hold and reset.
module tb_ram;

  localparam int AW    = 11;
  localparam int DW    = 64;
  localparam int DEPTH = 2048;

`ifdef RAM_CLEAR_EN
  localparam int NB_MODE = 1;
`else
  localparam int NB_MODE = 2;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          isReading;
  logic [AW-1:0] address;
  logic          drv_en;
  logic [DW-1:0] drv_val;
  wire  [0:DW-1] data;
  logic          ready;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string         name;
    bit            rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    int            mode;   // 0 = no check, 1 = data must equal exp, 2 = data must differ from exp
    logic [DW-1:0] exp;
  } vec_t;

  vec_t vecs[$];

  assign data = drv_en ? drv_val : 'z;

  always #5 clk = ~clk;

  ram #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .address  (address),
    .isReading(isReading),
    .data     (data),
    .ready    (ready)
  );

  function automatic vec_t mk(string n, bit rd, logic [AW-1:0] a,
                              logic [DW-1:0] wd, int mode, logic [DW-1:0] exp);
    vec_t v;
    v.name = n;
    v.rd   = rd;
    v.addr = a;
    v.wd   = wd;
    v.mode = mode;
    v.exp  = exp;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_eq(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_ne(input string name, input logic [DW-1:0] act, input logic [DW-1:0] bad);
    checks++;
    if (act === bad) begin
      failures++;
      $display("FAIL %s actual=%h required=not %h", name, act, bad);
    end
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] v);
    isReading = 1'b0;
    drv_en    = 1'b1;
    drv_val   = v;
    address   = a;
    step();
    drv_en    = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] a);
    drv_en    = 1'b0;
    isReading = 1'b1;
    address   = a;
    step();
  endtask

  // Deassert reset and wait until the ram reports ready; with the clear
  // sweep enabled, also count the not-ready edges and try a write mid-sweep
  task automatic release_reset();
    int n;
    n     = 0;
    reset = 1'b0;
`ifdef RAM_CLEAR_EN
    while (n < 3 * DEPTH) begin
      if (n == 99) begin
        isReading = 1'b0;
        address   = 11'd1500;
        drv_val   = 64'hbeef_beef_beef_beef;
        drv_en    = 1'b1;
      end
      step();
      drv_en    = 1'b0;
      isReading = 1'b1;
      if (ready === 1'b1) break;
      n++;
      if (n == 50) chk_eq("sweep_rdq_zero", data, '0);
    end
    chk_eq("sweep_len", 64'(n), 64'(DEPTH));
`else
    step();
    chk_eq("ready_after_release", {63'b0, ready}, 64'd1);
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    isReading = 1'b1;
    drv_en    = 1'b0;
    drv_val   = '0;
    address   = '0;

    vecs.push_back(mk("wr_1024",     1'b0, 11'd1024, 64'hff03,             0, '0));
    vecs.push_back(mk("rd_1024",     1'b1, 11'd1024, '0,                   1, 64'h0000_0000_0000_ff03));
    vecs.push_back(mk("nb_1023_a",   1'b1, 11'd1023, '0,             NB_MODE, (NB_MODE == 1) ? 64'h0 : 64'hff03));
    vecs.push_back(mk("nb_1023_b",   1'b1, 11'd1023, '0,             NB_MODE, (NB_MODE == 1) ? 64'h0 : 64'hff03));
    vecs.push_back(mk("nb_1023_c",   1'b1, 11'd1023, '0,             NB_MODE, (NB_MODE == 1) ? 64'h0 : 64'hff03));
    vecs.push_back(mk("wr_0",        1'b0, 11'd0,    64'hA5A5A5A5A5A5A5A5, 0, '0));
    vecs.push_back(mk("wr_2047",     1'b0, 11'd2047, 64'h5A5A5A5A5A5A5A5A, 0, '0));
    vecs.push_back(mk("rd_0",        1'b1, 11'd0,    '0,                   1, 64'hA5A5A5A5A5A5A5A5));
    vecs.push_back(mk("rd_2047",     1'b1, 11'd2047, '0,                   1, 64'h5A5A5A5A5A5A5A5A));
    vecs.push_back(mk("wr_1",        1'b0, 11'd1,    64'h1111_2222_3333_4444, 0, '0));
    vecs.push_back(mk("wr_2046",     1'b0, 11'd2046, 64'h8000_0000_0000_0001, 0, '0));
    vecs.push_back(mk("rd_0_again",  1'b1, 11'd0,    '0,                   1, 64'hA5A5A5A5A5A5A5A5));
    vecs.push_back(mk("rd_2047_agn", 1'b1, 11'd2047, '0,                   1, 64'h5A5A5A5A5A5A5A5A));
    vecs.push_back(mk("rd_1",        1'b1, 11'd1,    '0,                   1, 64'h1111_2222_3333_4444));
    vecs.push_back(mk("rd_2046",     1'b1, 11'd2046, '0,                   1, 64'h8000_0000_0000_0001));
    vecs.push_back(mk("rd_1024_agn", 1'b1, 11'd1024, '0,                   1, 64'h0000_0000_0000_ff03));

    // Reset state
    step();
    step();
    chk_eq("reset_ready", {63'b0, ready}, 64'd0);
    chk_eq("reset_rdq", data, '0);
    release_reset();

    // Table-driven accesses
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rd) do_read(vecs[i].addr);
      else            do_write(vecs[i].addr, vecs[i].wd);
      if (vecs[i].mode == 1)      chk_eq(vecs[i].name, data, vecs[i].exp);
      else if (vecs[i].mode == 2) chk_ne(vecs[i].name, data, vecs[i].exp);
    end

    // Bus direction without a clock edge (rd_q currently holds ff03)
    isReading = 1'b0;
    #1;
    chk_ne("release_bus", data, 64'hff03);
    drv_en  = 1'b1;
    drv_val = '0;
    #1;
    chk_eq("no_contention", data, '0);
    drv_en    = 1'b0;
    isReading = 1'b1;
    #1;
    chk_eq("drive_immediate", data, 64'hff03);

    // rd_q holds across a write edge and reappears on return to read
    do_write(11'd5, 64'h7777_7777_7777_7777);
    isReading = 1'b1;
    #1;
    chk_eq("rdq_hold", data, 64'hff03);
    do_read(11'd5);
    chk_eq("rd_5", data, 64'h7777_7777_7777_7777);

    // Reset mid-operation: write ignored, rd_q cleared, read ignored
    do_read(11'd1024);
    chk_eq("pre_reset_rd", data, 64'hff03);
    reset     = 1'b1;
    isReading = 1'b0;
    drv_en    = 1'b1;
    drv_val   = 64'hdead_dead_dead_dead;
    address   = 11'd1024;
    step();
    drv_en    = 1'b0;
    isReading = 1'b1;
    step();
    chk_eq("reset_clears_rdq", data, '0);
    chk_eq("reset_ready_low", {63'b0, ready}, 64'd0);
    release_reset();
    do_read(11'd1024);
`ifdef RAM_CLEAR_EN
    chk_eq("post_sweep_1024", data, '0);
    do_read(11'd1500);
    chk_eq("lost_sweep_write", data, '0);
`else
    chk_eq("mem_kept_1024", data, 64'hff03);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
